// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states and the width of the iteration counter.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// One-bit-per-cycle shared datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic [WIDTH-1:0]        a_mag,
  input  logic [WIDTH-1:0]        b_mag,
  output logic [cnt_w(WIDTH)-1:0] count_o,
  output logic [WIDTH-1:0]        hi_o,
  output logic [WIDTH-1:0]        lo_o
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d, sreg_q, sreg_d, opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH+1:0] div_diff;

  // Multiply keeps {acc,sreg} as the running product; divide keeps acc as remainder, sreg as dividend/quotient.
  assign mul_sum  = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_q, sreg_q[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd_q};

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    sreg_d  = sreg_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    if (load) begin
      count_d = '0;
      acc_d   = '0;
      sreg_d  = a_mag;
      opnd_d  = b_mag;
      div_d   = is_div;
    end else if (step) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      if (div_q) begin
        acc_d  = div_diff[WIDTH+1] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        sreg_d = {sreg_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else begin
        acc_d  = mul_sum[WIDTH:1];
        sreg_d = {mul_sum[0], sreg_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    sreg_q <= sreg_d;
    opnd_q <= opnd_d;
    div_q  <= div_d;
  end

  assign count_o = count_q;
  assign hi_o    = acc_q;
  assign lo_o    = sreg_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO.
// Define HILO_BYPASS_EN to forward same-cycle HI/LO write data onto hi_rdata/lo_rdata.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               stallreq,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH-1:0]   hi_rdata,
  output logic [WIDTH-1:0]   lo_rdata
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, araw_q, araw_d;
  logic               div_zero_q, div_zero_d, dz_op_q, dz_op_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, isdiv_q, isdiv_d;
  logic               wr_hi, wr_lo;

  logic               accept, start_md, is_md, is_dv, sgn, sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  assign is_md    = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);
  assign is_dv    = (op == OP_DIV) | (op == OP_DIVU);
  assign sgn      = (op == OP_MULT) | (op == OP_DIV);
  assign sa       = sgn & src_a[WIDTH-1];
  assign sb       = sgn & src_b[WIDTH-1];
  // Unsigned W-bit magnitude already covers -2^(W-1), so the most-negative operand needs no special case.
  assign a_mag    = sa ? (~src_a + 1'b1) : src_a;
  assign b_mag    = sb ? (~src_b + 1'b1) : src_b;
  assign accept   = start & ~stall[STALL_IDX] & ~flush & (state_q == ST_IDLE);
  assign start_md = accept & is_md;

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (start_md),
    .step    ((state_q == ST_RUN) & ~dz_op_q),
    .is_div  (is_dv),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .count_o (count),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  assign prod = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (dz_op_q) begin
      res_hi = araw_q;
      res_lo = '1;
    end else if (isdiv_q) begin
      res_hi = rneg_q ? -core_hi : core_hi;
      res_lo = neg_q  ? -core_lo : core_lo;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    div_zero_d = div_zero_q;
    dz_op_d    = dz_op_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    isdiv_d    = isdiv_q;
    araw_d     = araw_q;
    case (state_q)
      ST_IDLE: if (start_md) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)                         state_d = ST_IDLE;
        else if (dz_op_q || count == LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      div_zero_d = is_dv & (src_b == '0);
      if (op == OP_MTHI) begin
        hi_d  = src_a;
        wr_hi = 1'b1;
      end
      if (op == OP_MTLO) begin
        lo_d  = src_a;
        wr_lo = 1'b1;
      end
    end
    if (start_md) begin
      dz_op_d = is_dv & (src_b == '0);
      neg_d   = sa ^ sb;
      rneg_d  = sa;
      isdiv_d = is_dv;
      araw_d  = src_a;
    end
    // The DONE write is committed regardless of stall or flush.
    if (state_q == ST_DONE) begin
      hi_d  = res_hi;
      lo_d  = res_lo;
      wr_hi = 1'b1;
      wr_lo = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      dz_op_q    <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      isdiv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      dz_op_q    <= dz_op_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      isdiv_q    <= isdiv_d;
    end
  end

  always_ff @(posedge clk) araw_q <= araw_d;

  assign stallreq = start_md | (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign div_zero = div_zero_q;

`ifdef HILO_BYPASS_EN
  assign hi_rdata = wr_hi ? hi_d : hi_q;
  assign lo_rdata = wr_lo ? lo_d : lo_q;
`else
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit at WIDTH=32: directed cases plus a short random mul/div sweep.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, done, div_zero;
  logic [31:0] hi_rdata, lo_rdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_unit #(.WIDTH(32), .STALL_W(6), .STALL_IDX(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .stallreq(stallreq), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] ua, ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if ((o == OP_DIV || o == OP_DIVU) && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      OP_MULT:  begin r = sa * sb; return r; end
      OP_MULTU: return ua * ub;
      OP_DIV:   begin r = sa / sb; sa = sa % sb; return {sa[31:0], r[31:0]}; end
      default:  begin ua = ua / ub; ub = {32'd0, a} % ub; return {ub[31:0], ua[31:0]}; end
    endcase
  endfunction

  task automatic run_mt(input logic [2:0] o, input logic [31:0] d);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = d; src_b = 32'd0;
    #1;
    check("mt_stallreq", stallreq, 0);
`ifdef HILO_BYPASS_EN
    check("mt_bypass", (o == OP_MTHI) ? hi_rdata : lo_rdata, d);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("mt_value", (o == OP_MTHI) ? hi_rdata : lo_rdata, d);
    check("mt_busy", busy, 0);
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic [63:0] e;
    logic dz;
    dz = (o == OP_DIV || o == OP_DIVU) && (b == 32'd0);
    exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check("acc_stallreq", stallreq, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("run_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check("done_timeout", 0, 1);
    else       check("latency", cyc, dz ? 1 : 32);
    check("done_stallreq", stallreq, 0);
    check("div_zero", div_zero, dz);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("hi", hi_rdata, e[63:32]);
    check("lo", lo_rdata, e[31:0]);
    check("done_pulse", done, 0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b0; stall = '0; flush = 1'b0; start = 1'b0; op = OP_MULT; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_rdata, 0);
    check("rst_lo", lo_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_stallreq", stallreq, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b1;

    run_mt(OP_MTHI, 32'h1234_5678);
    run_mt(OP_MTLO, 32'hDEAD_BEEF);
    check("mt_hi_kept", hi_rdata, 32'h1234_5678);

    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_const", {hi_rdata, lo_rdata}, 64'hFFFF_FFFE_0000_0001);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_const", {hi_rdata, lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_const", {hi_rdata, lo_rdata}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_md(OP_DIVU, 32'd100, 32'd0);
    check("divz_const", {hi_rdata, lo_rdata}, 64'h0000_0064_FFFF_FFFF);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("minneg_const", {hi_rdata, lo_rdata}, 64'h0000_0000_8000_0000);
    check("dz_cleared", div_zero, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = (i == 3) ? 32'd0 : $urandom;
      run_md(3'($urandom_range(0, 3)), $urandom, b);
    end

    // flush during RUN discards the op
    run_mt(OP_MTHI, 32'd5);
    run_mt(OP_MTLO, 32'd5);
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen_done |= done;
    check("flush_busy", busy, 0);
    check("flush_nodone", seen_done, 0);
    check("flush_hi", hi_rdata, 5);
    check("flush_lo", lo_rdata, 5);
    run_md(OP_MULTU, 32'd2, 32'd3);

    // flush coincident with start blocks acceptance
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'hAAAA_5555;
    #1;
    check("flush_acc_stallreq", stallreq, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_acc_hi", hi_rdata, 0);
    check("flush_acc_busy", busy, 0);

    // asynchronous reset mid-divide
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_hi", hi_rdata, 0);
    check("arst_lo", lo_rdata, 0);
    check("arst_busy", busy, 0);
    check("arst_stallreq", stallreq, 0);
    #2;
    rst = 1'b1;

    // start held off by stall bit
    @(posedge clk); #1;
    stall = 6'b000100; start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd3;
    #1;
    check("stall_stallreq", stallreq, 0);
    @(posedge clk); #1;
    check("stall_busy", busy, 0);
    start = 1'b0; stall = '0;
    @(posedge clk); #1;
    check("stall_lo", lo_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
